pwm_av_pwm_gen: RTL and testbench
=================================

# pwm_av_pwm_gen

Avalon-MM slave PWM generator in the `pwm_av` system. It sits alongside the LED PIO on the same slave port style and drives the LED/actuator line that the PIO's static `out_port` cannot modulate. Software programs period, duty, enable and polarity. A free-running counter produces a glitch-free PWM waveform, with double-buffered period/duty updates applied only at period boundaries.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  system clock; all state is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select: 0 CTRL, 1 PERIOD, 2 DUTY, 3 COUNT.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata`  in  32  write data.
- `readdata`  out  32  combinational read mux of the register at `address`; zero wait states.
- `pwm_out`  out  1  registered PWM output.
- `period_tick`  out  1  registered one-cycle pulse at each counter wrap.

## Operation
- CTRL (addr 0)
  - bit0 `en`; bit1 `pol` (1 inverts the output).
  - Bits 31:2 are ignored on write and read as 0.
- PERIOD (addr 1) and DUTY (addr 2): 32-bit unsigned, read/write.
- COUNT (addr 3): read-only current counter; writes are ignored.
- Reset values: CTRL, PERIOD, DUTY, counter and both shadow registers are 0; `pwm_out` and `period_tick` are 0.
- Shadow registers `per_a` and `duty_a` are the values actually used for generation.
  - While `en`=0: counter is held at 0, and the shadows load PERIOD/DUTY every clock.
  - While `en`=1 and `per_a`≠0: counter increments each clock. When counter == `per_a`-1:
    - counter goes to 0;
    - shadows load the PERIOD/DUTY values held before that edge;
    - `period_tick` is 1 in the following cycle.
  - While `en`=1 and `per_a`=0: counter stays at 0, `period_tick` stays 0, and the shadows keep loading every clock. This lets the generator start once PERIOD is written non-zero.
- Output computation, registered each clock:
  - `en`=1: `pwm_out` <= (counter < `duty_a`) XOR `pol`, with `per_a`=0 forcing the raw term to 0.
  - `en`=0: `pwm_out` <= `pol` (idle level).
- Boundary rules:
  - `duty_a` ≥ `per_a` (non-zero): raw output is constantly 1.
  - `duty_a`=0: raw output is constantly 0.
  - The comparison is 32-bit unsigned, and the counter never exceeds `per_a`-1.
  - Writing PERIOD or DUTY mid-period does not change the current period. It takes effect from the first cycle after the next wrap.
  - Clearing `en` mid-period: counter returns to 0 on the next edge, and `pwm_out` goes to `pol` on that same edge.
  - A write and a wrap on the same edge: the shadows get the old register value, and the new value applies at the following wrap.
  - Asynchronous reset mid-operation returns every register and output to its reset value immediately.

## Timing
- Register write at edge N is visible on `readdata` and to the logic from cycle N+1.
- `readdata` has zero latency from `address`.
- `pwm_out` lags the counter value by exactly one clock.
- CTRL write setting `en` at edge E0, with shadows (P,D):
  - the counter first reads 1 after E1;
  - the first active `pwm_out` cycle begins after E1;
  - `pwm_out` high time is D cycles of every P (for D<P).
- `period_tick` asserts for one cycle every P cycles, starting the cycle after the counter wraps.

## Test plan
- Reset: hold `reset_n`=0 mid-waveform → `pwm_out`=0, `period_tick`=0, and all four registers read 0 immediately.
- Basic PWM: PERIOD=4, DUTY=1, CTRL=1 → `pwm_out` pattern 1,0,0,0 repeating from the cycle after E1; `period_tick` every 4 cycles; COUNT reads cycle 0..3.
- Polarity/idle: CTRL=2 → `pwm_out`=1 constant. CTRL=3 with PERIOD=4, DUTY=1 → pattern 0,1,1,1.
- Double buffering: running PERIOD=8, DUTY=2; write DUTY=6 at count 3 → remainder of the current period still shows 2 high. The next period shows 6 high of 8, and the change aligns with `period_tick`.
- Edge values:
  - DUTY=10 with PERIOD=4 → constant 1.
  - DUTY=0 → constant 0.
  - PERIOD=0 with `en`=1 → `pwm_out`=0 and no ticks. Then write PERIOD=3 → ticks resume within 4 cycles.
- Register access: write 0xFFFFFFFF to CTRL → reads 0x3. Write to COUNT → ignored. A write with `chipselect`=0 → no register change.

Source files
------------

// File: rtl/pwm_av_pwm_gen_if.sv
// Avalon-MM slave bus bundle for the pwm_av PWM generator.
//   address    : 2-bit register select (0 CTRL, 1 PERIOD, 2 DUTY, 3 COUNT)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data (combinational, zero wait states)
// The master modport is the bus owner (CPU side or testbench);
// the slave modport is the PWM generator.
interface pwm_av_pwm_gen_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pwm_av_pwm_gen.sv
// PWM generator with an Avalon-MM slave register port.
// Ports:
//   clk         : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   bus         : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   pwm_out     : registered PWM output
//   period_tick : registered one-cycle pulse after each counter wrap
// Registers: CTRL (bit0 en, bit1 pol), PERIOD, DUTY, COUNT (read-only).
// PERIOD/DUTY are copied into shadow registers that drive the waveform;
// the copy happens every clock while idle (or PERIOD=0) and only at a
// wrap while running, so software updates never cut a period short.
module pwm_av_pwm_gen (
  input  logic                 clk,
  input  logic                 reset_n,
  pwm_av_pwm_gen_if.slave      bus,
  output logic                 pwm_out,
  output logic                 period_tick
);

  logic        en_reg;
  logic        pol_reg;
  logic [31:0] period_reg;
  logic [31:0] duty_reg;
  logic [31:0] count_reg;
  logic [31:0] per_a_reg;
  logic [31:0] duty_a_reg;
  logic        pwm_out_reg;
  logic        tick_reg;

  logic        wr_en;
  logic        running;
  logic        at_wrap;
  logic        raw_pwm;

  assign wr_en   = bus.chipselect && !bus.write_n;
  assign running = en_reg && (per_a_reg != 32'd0);
  // per_a_reg is non-zero whenever running, so the subtraction cannot wrap.
  assign at_wrap = running && (count_reg >= (per_a_reg - 32'd1));
  assign raw_pwm = (per_a_reg != 32'd0) && (count_reg < duty_a_reg);

  // Software-visible registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_reg     <= 1'b0;
      pol_reg    <= 1'b0;
      period_reg <= 32'd0;
      duty_reg   <= 32'd0;
    end else if (wr_en) begin
      unique case (bus.address)
        2'd0: begin
          en_reg  <= bus.writedata[0];
          pol_reg <= bus.writedata[1];
        end
        2'd1: period_reg <= bus.writedata;
        2'd2: duty_reg   <= bus.writedata;
        default: ; // COUNT is read-only
      endcase
    end
  end

  // Counter, shadow registers and registered outputs. Shadows always take
  // the PERIOD/DUTY values from before this edge, so a write coinciding
  // with a wrap lands at the following wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg   <= 32'd0;
      per_a_reg   <= 32'd0;
      duty_a_reg  <= 32'd0;
      pwm_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      if (!running) begin
        count_reg  <= 32'd0;
        per_a_reg  <= period_reg;
        duty_a_reg <= duty_reg;
        tick_reg   <= 1'b0;
      end else if (at_wrap) begin
        count_reg  <= 32'd0;
        per_a_reg  <= period_reg;
        duty_a_reg <= duty_reg;
        tick_reg   <= 1'b1;
      end else begin
        count_reg  <= count_reg + 32'd1;
        tick_reg   <= 1'b0;
      end

      // Output lags the counter by one clock; idle level is the polarity.
      if (en_reg) begin
        pwm_out_reg <= raw_pwm ^ pol_reg;
      end else begin
        pwm_out_reg <= pol_reg;
      end
    end
  end

  assign pwm_out     = pwm_out_reg;
  assign period_tick = tick_reg;

  // Zero-latency read mux.
  always_comb begin
    bus.readdata = 32'd0;
    unique case (bus.address)
      2'd0:    bus.readdata = {30'd0, pol_reg, en_reg};
      2'd1:    bus.readdata = period_reg;
      2'd2:    bus.readdata = duty_reg;
      default: bus.readdata = count_reg;
    endcase
  end

endmodule

// File: tb/tb_pwm_av_pwm_gen.sv
module tb_pwm_av_pwm_gen;

  logic clk;
  logic reset_n;
  logic pwm_out;
  logic period_tick;

  pwm_av_pwm_gen_if bus ();

  pwm_av_pwm_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (behaviour described by the register rules).
  logic        m_en, m_pol;
  logic [31:0] m_period, m_duty;
  logic [31:0] m_cnt, m_pa, m_da;
  logic        m_pwm, m_tick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, m_pol, m_en};
      2'd1:    return m_period;
      2'd2:    return m_duty;
      default: return m_cnt;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_pol = 0; m_period = 0; m_duty = 0;
    m_cnt = 0; m_pa = 0; m_da = 0; m_pwm = 0; m_tick = 0;
  endtask

  // Advance one clock: update the model from the bus as it stands at the
  // edge, then compare the DUT just after the edge.
  task automatic step();
    logic        wr;
    logic        raw;
    logic [63:0] nxt;
    wr = bus.chipselect && !bus.write_n;
    // Raw level from the boundary rules.
    if (m_pa == 0)          raw = 1'b0;
    else if (m_da >= m_pa)  raw = 1'b1;
    else                    raw = (m_cnt < m_da);
    m_pwm = m_en ? (raw ^ m_pol) : m_pol;
    if (!m_en || m_pa == 0) begin
      m_cnt = 0; m_tick = 0;
      m_pa = m_period; m_da = m_duty;
    end else begin
      nxt = ({32'd0, m_cnt} + 64'd1) % {32'd0, m_pa};
      m_tick = (nxt == 64'd0);
      m_cnt  = nxt[31:0];
      if (m_tick) begin
        m_pa = m_period; m_da = m_duty;
      end
    end
    if (wr) begin
      case (bus.address)
        2'd0: begin m_en = bus.writedata[0]; m_pol = bus.writedata[1]; end
        2'd1: m_period = bus.writedata;
        2'd2: m_duty = bus.writedata;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    check("pwm_out", {31'd0, pwm_out}, {31'd0, m_pwm});
    check("period_tick", {31'd0, period_tick}, {31'd0, m_tick});
    check("readdata", bus.readdata, model_read(bus.address));
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1; bus.write_n = 0; bus.address = a; bus.writedata = d;
    step();
    bus.chipselect = 0; bus.write_n = 1;
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    bus.chipselect = 0; bus.write_n = 1; bus.address = a;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all_regs_zero(input string tag);
    for (int a = 0; a < 4; a++) begin
      bus.address = a[1:0];
      #0.1;
      check(tag, bus.readdata, 32'd0);
    end
  endtask

  initial begin
    int guard;
    bit seen;
    int highs;
    bus.address = 0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pwm", {31'd0, pwm_out}, 32'd0);
    check("rst_tick", {31'd0, period_tick}, 32'd0);
    check_all_regs_zero("rst_reg");
    #2 reset_n = 1;

    // Basic PWM: 4/1 -> 1,0,0,0
    write_reg(2'd1, 32'd4);
    write_reg(2'd2, 32'd1);
    write_reg(2'd0, 32'd1);
    highs = 0;
    bus.address = 2'd3;
    for (int i = 0; i < 8; i++) begin
      step();
      highs += int'(pwm_out);
    end
    check("basic_high_count", highs, 32'd2);
    idle(4, 2'd3);

    // Polarity / idle
    write_reg(2'd0, 32'd2);
    idle(5, 2'd0);
    check("idle_pol", {31'd0, pwm_out}, 32'd1);
    write_reg(2'd0, 32'd3);
    idle(9, 2'd3);

    // Double buffering: 8/2, change duty to 6 at count 3
    write_reg(2'd0, 32'd0);
    write_reg(2'd1, 32'd8);
    write_reg(2'd2, 32'd2);
    write_reg(2'd0, 32'd1);
    guard = 0;
    bus.address = 2'd3;
    while (m_cnt != 3 && guard < 20) begin step(); guard++; end
    check("dbuf_reach_cnt3", {31'd0, (guard < 20)}, 32'd1);
    write_reg(2'd2, 32'd6);
    idle(20, 2'd3);

    // Edge values
    write_reg(2'd1, 32'd4);
    write_reg(2'd2, 32'd10);
    idle(10, 2'd3);
    write_reg(2'd2, 32'd0);
    idle(10, 2'd3);
    write_reg(2'd1, 32'd0);
    idle(8, 2'd3);
    write_reg(2'd1, 32'd3);
    seen = 0;
    bus.address = 2'd3;
    for (int i = 0; i < 6; i++) begin
      step();
      if (period_tick) seen = 1;
    end
    check("tick_resume", {31'd0, seen}, 32'd1);

    // Register access
    write_reg(2'd0, 32'hFFFF_FFFF);
    idle(1, 2'd0);
    write_reg(2'd3, 32'h1234_5678);
    idle(2, 2'd3);
    bus.chipselect = 0; bus.write_n = 0; bus.address = 2'd1; bus.writedata = 32'hDEAD_BEEF;
    step();
    bus.write_n = 1;
    idle(2, 2'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        logic [1:0] a;
        logic [31:0] d;
        a = 2'($urandom_range(0, 3));
        case (a)
          2'd0: d = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : (32'd1 | 32'($urandom_range(0, 1) << 1));
          2'd1: d = 32'($urandom_range(0, 12));
          2'd2: d = 32'($urandom_range(0, 14));
          default: d = $urandom;
        endcase
        write_reg(a, d);
      end else begin
        idle(1, 2'($urandom_range(0, 3)));
      end
    end

    // Asynchronous reset mid-operation
    write_reg(2'd0, 32'd1);
    write_reg(2'd1, 32'd5);
    idle(7, 2'd3);
    #3 reset_n = 0;
    model_reset();
    #1;
    check("async_rst_pwm", {31'd0, pwm_out}, 32'd0);
    check("async_rst_tick", {31'd0, period_tick}, 32'd0);
    check_all_regs_zero("async_rst_reg");
    #1 reset_n = 1;
    idle(4, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
